// File: rtl/reg_file_sb.sv
// Register file with a per-register pending (scoreboard) bit for in-order issue.
// Reads are combinational; writeback clears pending and issue sets it.
module reg_file_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ok,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [ADDR_W:0]   r_pend_cnt;

  logic              w_wr_zero;
  logic              w_iss_zero;
  logic              w_wr_act;
  logic              w_set;
  logic              w_clr;
  logic [DEPTH-1:0]  w_pend_nxt;

  assign w_wr_zero  = (ZERO_R0 != 0) && (wr_addr == '0);
  assign w_iss_zero = (ZERO_R0 != 0) && (issue_rd == '0);
  assign w_wr_act   = wr_en && !w_wr_zero;

  // Acceptance looks only at pre-edge pending state, so a same-cycle writeback cannot unblock it.
  assign issue_ok = rst && issue_en && (w_iss_zero || !r_pend[issue_rd]);
  assign w_set    = issue_ok && !w_iss_zero;
  assign w_clr    = w_wr_act && r_pend[wr_addr];
  assign pend_cnt = r_pend_cnt;

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_clr) w_pend_nxt[wr_addr] = 1'b0;
    if (w_set) w_pend_nxt[issue_rd] = 1'b1;
  end

  always_comb begin
    rs_data = '0;
    rs_busy = 1'b0;
    if (rst && !((ZERO_R0 != 0) && (rs_addr == '0))) begin
      if ((BYPASS != 0) && w_wr_act && (wr_addr == rs_addr)) begin
        rs_data = wr_data;
      end else begin
        rs_data = r_regs[rs_addr];
        rs_busy = r_pend[rs_addr];
      end
    end
  end

  always_comb begin
    rt_data = '0;
    rt_busy = 1'b0;
    if (rst && !((ZERO_R0 != 0) && (rt_addr == '0))) begin
      if ((BYPASS != 0) && w_wr_act && (wr_addr == rt_addr)) begin
        rt_data = wr_data;
      end else begin
        rt_data = r_regs[rt_addr];
        rt_busy = r_pend[rt_addr];
      end
    end
  end

  // A set and a clear can never hit the same bit in one cycle, so the count moves by set minus clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_wr_act) r_regs[wr_addr] <= wr_data;
      r_pend <= w_pend_nxt;
      if (w_set && !w_clr) begin
        r_pend_cnt <= r_pend_cnt + CNT_ONE;
      end else if (w_clr && !w_set) begin
        r_pend_cnt <= r_pend_cnt - CNT_ONE;
      end
    end
  end

endmodule
